// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/halfword/word accesses to a word-wide data
// memory. A sub-word store is done as a read-modify-write of the whole word.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, RSP} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              req_err;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;
    logic [31:0]       merged;

    assign accept = req_valid && req_ready;

    // Reject bad width codes, misaligned accesses, unsigned stores and
    // addresses beyond the memory.
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = req_addr[0];
            3'b010:         req_err = |req_addr[1:0];
            default:        req_err = 1'b1;
        endcase
        if (req_we && req_funct3[2])
            req_err = 1'b1;
        if ((req_addr >> (ADDR_W + 2)) != 32'd0)
            req_err = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; SW skips the read, errors skip memory entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = RSP;
                    else if (!req_we)
                        state_nxt = RD;
                    else if (req_funct3 == 3'b010)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = LAT;
            LAT:     state_nxt = we_q ? WR : RSP;
            WR:      state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and strobes decoded purely from the state register.
    always_comb begin
        req_ready = (state == IDLE);
        mem_re    = (state == RD);
        mem_we    = (state == WR);
        rsp_valid = (state == RSP);
    end

    // Request capture at accept and memory word capture at the end of LAT.
    // The word index only moves for requests that will touch memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
                err_q   <= req_err;
                if (!req_err)
                    addr_q <= req_addr[ADDR_W+1:2];
            end
            if (state == LAT)
                rdata_q <= mem_rdata;
        end
    end

    // Lane selection, load extension and store merge (little-endian lanes).
    always_comb begin
        ld_byte = rdata_q[{lane_q, 3'b000} +: 8];
        ld_half = rdata_q[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = rdata_q;
        endcase
        merged = rdata_q;
        if (f3_q[1:0] == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = (state != WR)     ? 32'd0   :
                       (f3_q == 3'b010)  ? wdata_q : merged;
    assign rsp_rdata = (state == RSP && !we_q && !err_q) ? ld_ext : 32'd0;
    assign rsp_err   = (state == RSP) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data memory, reference model that
// predicts each response, and a scoreboard checked when rsp_valid fires.
module tb_load_store_unit;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nre;
        int          nwe;
        logic        chkw;
        logic [31:0] wword;
        logic [7:0]  idx;
    } exp_t;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    exp_t        sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0, re_c = 0, we_c = 0;
    int tot_we = 0, tot_rsp = 0;
    logic armed = 1'b0;
    logic [31:0] last_w = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Data memory: read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Monitor: per-request cycle/strobe counts and scoreboard pop on rsp_valid.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin cyc = 1; re_c = 0; we_c = 0; end
        else cyc++;
        if (mem_re || mem_we) begin
            chk("strobe_excl", {31'd0, mem_re & mem_we}, 32'd0);
            if (sb.size() != 0) chk("mem_addr", {24'd0, mem_addr}, {24'd0, sb[0].idx});
        end
        if (mem_re) re_c++;
        if (mem_we) begin we_c++; tot_we++; last_w = mem_wdata; end
        if (rsp_valid) begin
            tot_rsp++;
            if (sb.size() == 0) begin
                chk("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_err",   {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("latency",   cyc,  e.lat);
                chk("n_mem_re",  re_c, e.nre);
                chk("n_mem_we",  we_c, e.nwe);
                if (e.chkw) chk("mem_wdata", last_w, e.wword);
            end
        end
        armed = rst_n && req_valid && req_ready;
    end

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        logic [31:0] w, mask;
        logic [7:0]  b;
        logic [15:0] h;
        e.idx   = a[9:2];
        e.rdata = 32'd0;
        e.chkw  = 1'b0;
        e.wword = 32'd0;
        w = ref_mem[e.idx];
        b = 8'(w >> (8 * a[1:0]));
        h = 16'(w >> (16 * a[1]));
        e.err = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) ||
                (f3 == 3'b010 && a[1:0] != 2'b00) ||
                (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ||
                (we && (f3 == 3'b100 || f3 == 3'b101)) ||
                (a[31:10] != 22'd0);
        if (e.err) begin
            e.lat = 1; e.nre = 0; e.nwe = 0;
        end else if (!we) begin
            e.lat = 3; e.nre = 1; e.nwe = 0;
            case (f3)
                3'b000:  e.rdata = {{24{b[7]}}, b};
                3'b001:  e.rdata = {{16{h[15]}}, h};
                3'b100:  e.rdata = {24'd0, b};
                3'b101:  e.rdata = {16'd0, h};
                default: e.rdata = w;
            endcase
        end else if (f3 == 3'b010) begin
            e.lat = 2; e.nre = 0; e.nwe = 1; e.chkw = 1'b1; e.wword = wd;
            ref_mem[e.idx] = wd;
        end else begin
            e.lat = 4; e.nre = 1; e.nwe = 1; e.chkw = 1'b1;
            if (f3 == 3'b000) begin
                mask    = 32'h0000_00FF << (8 * a[1:0]);
                e.wword = (w & ~mask) | (32'(wd[7:0]) << (8 * a[1:0]));
            end else begin
                mask    = 32'h0000_FFFF << (16 * a[1]);
                e.wword = (w & ~mask) | (32'(wd[15:0]) << (16 * a[1]));
            end
            ref_mem[e.idx] = e.wword;
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    endtask

    // Wait (bounded) for the accept edge; leaves the caller 1 time unit after it.
    task automatic wait_accept();
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (i == 20) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        exp_t e;
        model(we, f3, a, wd, e);
        sb.push_back(e);
        @(posedge clk); #1;
        drive(we, f3, a, wd);
        wait_accept();
        req_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int r0, w0;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0F0F;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h8899_AABB; ref_mem[3] = 32'h8899_AABB;
        mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;

        #23;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,          32'd0);
        chk("rst_mem_re",    {31'd0, mem_re},    32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", mem_wdata,          32'd0);
        rst_n = 1'b1;

        // Directed loads, sub-word store, errors.
        do_req(1'b0, 3'b000, 32'h0000_000D, 32'd0);          // LB  -> FFFFFFAA
        do_req(1'b0, 3'b101, 32'h0000_000E, 32'd0);          // LHU -> 00008899
        do_req(1'b0, 3'b010, 32'h0000_000C, 32'd0);          // LW  -> 8899AABB
        do_req(1'b0, 3'b001, 32'h0000_000E, 32'd0);          // LH  -> FFFF8899
        do_req(1'b0, 3'b100, 32'h0000_000F, 32'd0);          // LBU -> 00000088
        do_req(1'b1, 3'b001, 32'h0000_0016, 32'hFFFF_BEEF);  // SH  -> BEEF3344
        chk("mem5_after_sh", mem[5], 32'hBEEF_3344);
        do_req(1'b0, 3'b010, 32'h0000_000A, 32'd0);          // LW misaligned
        do_req(1'b1, 3'b000, 32'h0000_0400, 32'h0000_0055);  // SB out of range
        do_req(1'b0, 3'b001, 32'h0000_0011, 32'd0);          // LH odd address
        do_req(1'b0, 3'b011, 32'h0000_0010, 32'd0);          // reserved funct3
        do_req(1'b1, 3'b100, 32'h0000_0010, 32'd0);          // store with BU
        for (int k = 0; k < 4; k++)
            do_req(1'b1, 3'b000, 32'h0000_0020 + k, 32'h0000_00C0 + k);  // SB each lane
        do_req(1'b0, 3'b010, 32'h0000_0020, 32'd0);
        chk("mem8_after_sb", mem[8], 32'hC3C2_C1C0);

        // Back-to-back: req_valid held high for SW then LW to the same word.
        model(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, e); sb.push_back(e);
        model(1'b0, 3'b010, 32'h0000_0040, 32'd0, e);         sb.push_back(e);
        @(posedge clk); #1;
        drive(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        wait_accept();
        r0 = tot_rsp;
        drive(1'b0, 3'b010, 32'h0000_0040, 32'd0);
        wait_accept();
        chk("b2b_after_rsp", tot_rsp - r0, 32'd1);
        req_valid = 1'b0;
        wait_drain();

        // Random mix of legal and illegal requests.
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) a = a | 32'h0000_1000;
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        // Reset during LAT of an SB: no write, no response.
        @(posedge clk); #1;
        drive(1'b1, 3'b000, 32'h0000_0031, 32'h0000_00EE);
        wait_accept();
        req_valid = 1'b0;
        @(posedge clk); #1;
        w0 = tot_we; r0 = tot_rsp;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we",    {31'd0, mem_we},    32'd0);
        chk("abort_mem_re",    {31'd0, mem_re},    32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mem_addr",  {24'd0, mem_addr},  32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_we",        tot_we,  w0);
        chk("abort_no_rsp",       tot_rsp, r0);
        chk("abort_ready_after",  {31'd0, req_ready}, 32'd1);
        chk("abort_mem12_intact", mem[12], ref_mem[12]);

        do_req(1'b0, 3'b010, 32'h0000_0030, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning data-memory word-index width (2^ADDR_W words of 32 bits).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data; data is taken from the low byte, halfword or word, as selected by req_funct3.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  extended load result.
REQ-012 SHALL have port rsp_err  output  1  request rejected, qualified by rsp_valid.
REQ-013 SHALL have port mem_addr  output  ADDR_W  word index to data memory.
REQ-014 SHALL have port mem_re  output  1  memory read strobe.
REQ-015 SHALL have port mem_we  output  1  memory write strobe.
REQ-016 SHALL have port mem_wdata  output  32  full word to write.
REQ-017 SHALL have port mem_rdata  input  32  memory word, valid in the cycle after mem_re.

Function
REQ-018 SHALL implement FSM states IDLE, RD, LAT, WR, RSP.
REQ-019 SHALL assert req_ready only in IDLE.
REQ-020 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, and latch all req_* fields at that edge.
REQ-021 SHALL classify a request as an error, and go IDLE->RSP with no memory access, in any of these cases:
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- funct3 in {011, 110, 111};
- store with funct3 in {100, 101};
- addr[31:ADDR_W+2] nonzero.
REQ-022 SHALL drive mem_addr = latched addr[ADDR_W+1:2] in RD, LAT and WR; outside those states it SHALL hold the last value.
REQ-023 SHALL assert mem_re only in RD, and mem_we only in WR; the two strobes SHALL never be high together and each SHALL last exactly one cycle per request.
REQ-024 Load path SHALL be IDLE->RD->LAT->RSP; the unit SHALL register mem_rdata at the end of LAT.
REQ-025 SW path SHALL be IDLE->WR->RSP, with mem_wdata = req_wdata.
REQ-026 SB/SH path SHALL be IDLE->RD->LAT->WR->RSP (read-modify-write).
REQ-027 In the SB/SH merge, mem_wdata SHALL equal the read word with the addressed lane replaced:
- SB: byte addr[1:0] replaced;
- SH: halfword addr[1] replaced;
- all other bits unchanged.
REQ-028 SHALL select load lanes little-endian: byte lane addr[1:0], halfword lane addr[1].
REQ-029 SHALL extend load results as follows: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
REQ-030 SHALL assert rsp_valid for exactly one cycle, in RSP; RSP SHALL always return to IDLE on the next edge.
REQ-031 SHALL provide no response backpressure.
REQ-032 SHALL drive rsp_rdata = 0 for stores and errors, and rsp_err = 0 except for error responses.
REQ-033 Latency from accept edge to rsp_valid cycle SHALL be:
- error: 1 cycle;
- SW: 2 cycles;
- load: 3 cycles;
- SB/SH: 4 cycles.
REQ-034 SHALL ignore req_valid while not in IDLE, with no queuing; a new request SHALL be acceptable in the cycle after RSP.
REQ-035 SHALL decode mem_re, mem_we, req_ready and rsp_valid from the state register only.

Reset
REQ-036 While rst_n=0, the unit SHALL force state IDLE, with req_ready=1 and rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset asserted mid-operation SHALL immediately drop mem_re/mem_we with no partial write on later edges; no response for the aborted request SHALL ever be produced.

Verification
REQ-038 Load case: memory word 3 = 0x8899AABB; LB addr 0x0D -> single mem_re at index 3; rsp_rdata = 0xFFFFFFAA, 3 cycles after accept.
REQ-039 Load extension case: same word; LHU addr 0x0E -> 0x00008899; LW addr 0x0C -> 0x8899AABB; rsp_err=0.
REQ-040 Sub-word store case: word 5 = 0x11223344; SH addr 0x16, wdata 0xFFFFBEEF -> mem_we once with 0xBEEF3344, rsp_valid 4 cycles after accept, rsp_rdata=0.
REQ-041 Error case: LW addr 0x0000000A, and separately SB addr 0x00000400 with ADDR_W=8 -> rsp_valid+rsp_err after 1 cycle; no mem_re/mem_we.
REQ-042 Back-to-back case: req_valid held high with SW then LW to the same address -> second request accepted only in IDLE after the first RSP; the load returns the stored value.
REQ-043 Reset case: rst_n pulsed low during LAT of an SB -> no mem_we and no rsp_valid; req_ready=1 after reset release.
